node_route_sequencer: RTL and testbench

NODE_ROUTE_SEQUENCER -- requirements
Module: node_route_sequencer

---
 rtl/node_route_sequencer_if.sv | 35 +++
 rtl/node_route_sequencer.sv | 162 ++++++++++++++++
 tb/tb_node_route_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : node_route_sequencer_if
// Description : Control, sensor, route-table and status bundle of the
//               node route sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface node_route_sequencer_if;
    logic       start;
    logic       stop;
    logic [2:0] line_sensor;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] route_len;
    logic       robot_enabled;
    logic [1:0] turn_direction;
    logic       activate_pick_operation;
    logic       activate_place_operation;
    logic [3:0] node_index;
    logic       route_done;

    modport slave (
        input  start, stop, line_sensor, wr_en, wr_addr, wr_data, route_len,
        output robot_enabled, turn_direction, activate_pick_operation,
               activate_place_operation, node_index, route_done
    );

    modport master (
        output start, stop, line_sensor, wr_en, wr_addr, wr_data, route_len,
        input  robot_enabled, turn_direction, activate_pick_operation,
               activate_place_operation, node_index, route_done
    );
endinterface
`default_nettype wire

// File: rtl/node_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : node_route_sequencer
// Description : Walks a 16-entry route table node by node, issuing turn codes
//               and timed pick/place requests from debounced line sensors.
// Revision    : 1.0 - initial release
// ============================================================================
module node_route_sequencer #(
    parameter int DEBOUNCE  = 4,
    parameter int OP_CYCLES = 1000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    node_route_sequencer_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int OPW = $clog2(OP_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_OPERATE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [3:0]     tbl_q [16];
    logic [3:0]     node_index_q, node_index_d;
    logic [4:0]     len_q, len_d;
    logic           armed_q, armed_d;
    logic [DBW-1:0] ent_cnt_q, ent_cnt_d;
    logic [DBW-1:0] exit_cnt_q, exit_cnt_d;
    logic [OPW-1:0] op_cnt_q, op_cnt_d;
    logic           op_place_q, op_place_d;
    logic [1:0]     turn_q, turn_d;

    logic [4:0] w_len_eff;
    logic       w_on_node;
    logic       w_entry;
    logic       w_exit;
    logic       w_is_last;
    logic [1:0] w_op;
    logic       w_tbl_wr;

    assign w_len_eff = (bus.route_len > 5'd16) ? 5'd16 : bus.route_len;
    assign w_on_node = (bus.line_sensor == 3'b111);
    assign w_entry   = (state_q == S_RUN) && armed_q && w_on_node &&
                       (ent_cnt_q == DBW'(DEBOUNCE - 1));
    assign w_exit    = (state_q == S_RUN) && !armed_q && !w_on_node &&
                       (exit_cnt_q == DBW'(DEBOUNCE - 1));
    assign w_is_last = ({1'b0, node_index_q} == (len_q - 5'd1));
    assign w_op      = tbl_q[node_index_q][1:0];
    assign w_tbl_wr  = bus.wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            node_index_q <= 4'd0;
            len_q        <= 5'd0;
            armed_q      <= 1'b1;
            ent_cnt_q    <= '0;
            exit_cnt_q   <= '0;
            op_cnt_q     <= '0;
            op_place_q   <= 1'b0;
            turn_q       <= 2'b11;
            for (int i = 0; i < 16; i++) begin
                tbl_q[i] <= 4'b1100;
            end
        end else begin
            state_q      <= state_d;
            node_index_q <= node_index_d;
            len_q        <= len_d;
            armed_q      <= armed_d;
            ent_cnt_q    <= ent_cnt_d;
            exit_cnt_q   <= exit_cnt_d;
            op_cnt_q     <= op_cnt_d;
            op_place_q   <= op_place_d;
            turn_q       <= turn_d;
            if (w_tbl_wr) begin
                tbl_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        node_index_d = node_index_q;
        len_d        = len_q;
        armed_d      = armed_q;
        ent_cnt_d    = '0;
        exit_cnt_d   = '0;
        op_cnt_d     = op_cnt_q;
        op_place_d   = op_place_q;
        turn_d       = turn_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (w_len_eff != 5'd0) begin
                        state_d      = S_RUN;
                        node_index_d = 4'd0;
                        armed_d      = 1'b1;
                        len_d        = w_len_eff;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Only one debounce sequence runs at a time, selected by armed.
                if (armed_q) begin
                    ent_cnt_d = (w_on_node && !w_entry) ? ent_cnt_q + 1'b1 : '0;
                    if (w_entry) begin
                        armed_d = 1'b0;
                        if ((w_op == 2'b01) || (w_op == 2'b10)) begin
                            state_d    = S_OPERATE;
                            op_cnt_d   = OPW'(OP_CYCLES);
                            op_place_d = (w_op == 2'b10);
                        end else if (w_is_last) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    exit_cnt_d = (!w_on_node && !w_exit) ? exit_cnt_q + 1'b1 : '0;
                    if (w_exit) begin
                        armed_d      = 1'b1;
                        node_index_d = node_index_q + 4'd1;
                    end
                end
            end
            S_OPERATE: begin
                if (op_cnt_q <= OPW'(1)) begin
                    op_cnt_d = '0;
                    state_d  = w_is_last ? S_DONE : S_RUN;
                end else begin
                    op_cnt_d = op_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.stop) begin
            state_d  = S_IDLE;
            op_cnt_d = '0;
        end

        // Turn code is a registered lookup, so it trails node_index by a cycle.
        if (state_d == S_IDLE) begin
            turn_d = 2'b11;
        end else if (state_q == S_RUN) begin
            turn_d = tbl_q[node_index_q][3:2];
        end
    end

    always_comb begin
        bus.robot_enabled            = (state_q == S_RUN) || (state_q == S_OPERATE);
        bus.turn_direction           = turn_q;
        bus.activate_pick_operation  = (state_q == S_OPERATE) && !op_place_q;
        bus.activate_place_operation = (state_q == S_OPERATE) && op_place_q;
        bus.node_index               = node_index_q;
        bus.route_done               = (state_q == S_DONE);
    end
endmodule
`default_nettype wire

// File: tb/tb_node_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_route_sequencer
// Description : Vector table, directed corner sequences and randomized run
//               against a behavioural route model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_route_sequencer;
    localparam int DEB = 4;
    localparam int OPC = 1000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    node_route_sequencer_if bus ();

    node_route_sequencer #(.DEBOUNCE(DEB), .OP_CYCLES(OPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [2:0] s, input int n);
        bus.line_sensor = s;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic start_route(input logic [4:0] len);
        bus.route_len = len; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        bus.start = 0; bus.stop = 0; bus.line_sensor = 3'b010;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.route_len = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_OP = 2, M_DONE = 3;
    int         m_mode, m_idx, m_len, m_streak, m_op_left, m_kind;
    bit         m_armed;
    logic [1:0] m_turn;
    logic [3:0] m_tbl [16];

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_len = 0; m_streak = 0;
        m_op_left = 0; m_kind = 0; m_armed = 1; m_turn = 2'b11;
        for (int i = 0; i < 16; i++) m_tbl[i] = 4'b1100;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit we,
                              input logic [3:0] wa, input logic [3:0] wd,
                              input logic [2:0] sens, input logic [4:0] rl);
        int old_mode = m_mode;
        int old_idx  = m_idx;
        int eff      = (int'(rl) > 16) ? 16 : int'(rl);
        bit on       = (sens == 3'b111);
        int op;
        case (old_mode)
            M_IDLE, M_DONE: if (st) begin
                if (eff > 0) begin
                    m_mode = M_RUN; m_idx = 0; m_armed = 1; m_len = eff; m_streak = 0;
                end else m_mode = M_DONE;
            end
            M_RUN: begin
                // armed waits for a run of on-node samples, disarmed for off-node
                m_streak = (m_armed == on) ? m_streak + 1 : 0;
                if (m_streak == DEB) begin
                    m_streak = 0;
                    if (m_armed) begin
                        m_armed = 0;
                        op = int'(m_tbl[m_idx][1:0]);
                        if (op == 1 || op == 2) begin
                            m_mode = M_OP; m_op_left = OPC; m_kind = op;
                        end else if (m_idx == m_len - 1) m_mode = M_DONE;
                    end else begin
                        m_armed = 1; m_idx = (m_idx + 1) % 16;
                    end
                end
            end
            default: begin
                m_op_left--;
                if (m_op_left == 0) m_mode = (m_idx == m_len - 1) ? M_DONE : M_RUN;
            end
        endcase
        if (sp) begin m_mode = M_IDLE; m_streak = 0; m_op_left = 0; end
        if (m_mode == M_IDLE) m_turn = 2'b11;
        else if (old_mode == M_RUN) m_turn = m_tbl[old_idx][3:2];
        if (we && (old_mode == M_IDLE || old_mode == M_DONE)) m_tbl[wa] = wd;
    endtask

    function automatic logic [9:0] dut_outs();
        return {bus.robot_enabled, bus.turn_direction, bus.activate_pick_operation,
                bus.activate_place_operation, bus.node_index, bus.route_done};
    endfunction

    function automatic logic [9:0] model_outs();
        logic [3:0] idx = 4'(m_idx);
        return {(m_mode == M_RUN || m_mode == M_OP), m_turn,
                (m_mode == M_OP && m_kind == 1), (m_mode == M_OP && m_kind == 2),
                idx, (m_mode == M_DONE)};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int         reps;
        bit         st;
        bit         sp;
        logic [2:0] sens;
        logic [4:0] len;
        bit         e_en;
        logic [1:0] e_turn;
        logic [3:0] e_idx;
        bit         chk_idx;
        bit         e_done;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cnt;
        bit bad_place, bad_en, bad_idx;
        logic [3:0] act_idx;
        int seg_left;
        bit seg_on;
        logic [2:0] s;
        bit st, sp, we;
        logic [3:0] wa, wd;
        logic [4:0] rl;

        vecs[0]  = '{1, 1, 0, 3'b010, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[1]  = '{3, 0, 0, 3'b111, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[2]  = '{1, 0, 0, 3'b010, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[3]  = '{3, 0, 0, 3'b111, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[4]  = '{1, 0, 0, 3'b111, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[5]  = '{3, 0, 0, 3'b010, 5'd2,  1, 2'b11, 4'd0, 1, 0};
        vecs[6]  = '{1, 0, 0, 3'b010, 5'd2,  1, 2'b11, 4'd1, 1, 0};
        vecs[7]  = '{1, 0, 0, 3'b010, 5'd2,  1, 2'b11, 4'd1, 1, 0};
        vecs[8]  = '{4, 0, 0, 3'b111, 5'd2,  0, 2'b11, 4'd1, 1, 1};
        vecs[9]  = '{1, 1, 1, 3'b111, 5'd2,  0, 2'b11, 4'd0, 0, 0};
        vecs[10] = '{1, 1, 0, 3'b010, 5'd0,  0, 2'b11, 4'd0, 0, 1};
        vecs[11] = '{1, 1, 0, 3'b010, 5'd20, 1, 2'b11, 4'd0, 1, 0};
        vecs[12] = '{1, 0, 1, 3'b010, 5'd20, 0, 2'b11, 4'd0, 1, 0};

        do_reset();
        check("reset_outputs", 32'(dut_outs()), 32'({1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0}));

        for (int v = 0; v < 13; v++) begin
            bus.route_len = vecs[v].len;
            bus.line_sensor = vecs[v].sens;
            for (int r = 0; r < vecs[v].reps; r++) begin
                bus.start = vecs[v].st && (r == 0);
                bus.stop  = vecs[v].sp && (r == 0);
                tick();
            end
            bus.start = 0; bus.stop = 0;
            act_idx = vecs[v].chk_idx ? bus.node_index : vecs[v].e_idx;
            check($sformatf("vec%0d", v),
                  32'({bus.robot_enabled, bus.turn_direction, act_idx, bus.route_done}),
                  32'({vecs[v].e_en, vecs[v].e_turn, vecs[v].e_idx, vecs[v].e_done}));
        end

        // three clean nodes with turn codes straight/left/right
        do_reset();
        wr(4'd0, 4'b1100); wr(4'd1, 4'b0100); wr(4'd2, 4'b1000);
        start_route(5'd3);
        cyc(3'b010, 2);
        check("route_n0", 32'({bus.turn_direction, bus.node_index}), 32'({2'b11, 4'd0}));
        wr(4'd0, 4'b0000);
        cyc(3'b111, 6); cyc(3'b010, 6);
        check("route_n1", 32'({bus.turn_direction, bus.node_index}), 32'({2'b01, 4'd1}));
        cyc(3'b111, 6); cyc(3'b010, 6);
        check("route_n2", 32'({bus.turn_direction, bus.node_index}), 32'({2'b10, 4'd2}));
        cyc(3'b111, 3);
        check("route_not_done_yet", 32'(bus.route_done), 32'd0);
        cyc(3'b111, 1);
        check("route_done", 32'({bus.route_done, bus.robot_enabled, bus.node_index}),
              32'({1'b1, 1'b0, 4'd2}));
        start_route(5'd1);
        cyc(3'b010, 2);
        check("run_write_ignored", 32'(bus.turn_direction), 32'(2'b11));

        // pick held for the full operation time, then exit advances the index
        do_reset();
        wr(4'd0, 4'b1101);
        start_route(5'd2);
        cyc(3'b111, 4);
        cnt = 0; bad_place = 0; bad_en = 0; bad_idx = 0;
        for (int k = 0; k < 1100 && bus.activate_pick_operation; k++) begin
            cnt++;
            if (bus.activate_place_operation) bad_place = 1;
            if (!bus.robot_enabled) bad_en = 1;
            if (bus.node_index != 4'd0) bad_idx = 1;
            tick();
        end
        check("pick_cycles", 32'(cnt), 32'd1000);
        check("pick_side_outputs", 32'({bad_place, bad_en, bad_idx}), 32'd0);
        cyc(3'b010, 3);
        check("pick_exit_pending", 32'(bus.node_index), 32'd0);
        cyc(3'b010, 1);
        check("pick_exit_done", 32'(bus.node_index), 32'd1);

        // glitch rejection and a long node hold
        do_reset();
        start_route(5'd3);
        cyc(3'b111, 3); cyc(3'b010, 5);
        check("glitch_rejected", 32'(bus.node_index), 32'd0);
        cyc(3'b111, 50); cyc(3'b010, 4);
        check("long_hold_one_event", 32'(bus.node_index), 32'd1);
        cyc(3'b010, 10);
        check("long_hold_no_extra", 32'(bus.node_index), 32'd1);

        // reset in the middle of a place operation
        do_reset();
        wr(4'd0, 4'b0110);
        start_route(5'd2);
        cyc(3'b111, 4); cyc(3'b111, 10);
        check("place_active", 32'({bus.activate_place_operation, bus.activate_pick_operation}),
              32'(2'b10));
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_outs()),
              32'({1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0}));
        tick();
        reset = 1'b0;
        tick();
        start_route(5'd1);
        cyc(3'b010, 2);
        check("table_reset", 32'(bus.turn_direction), 32'(2'b11));

        // randomized run against the model
        do_reset();
        model_reset();
        seg_left = 0; seg_on = 0; rl = 5'd3;
        for (int c = 0; c < 15000; c++) begin
            if (seg_left == 0) begin
                seg_on = ~seg_on;
                seg_left = $urandom_range(1, 9);
            end
            seg_left--;
            s  = seg_on ? 3'b111 : 3'($urandom_range(0, 6));
            st = (m_mode == M_IDLE || m_mode == M_DONE) ? ($urandom_range(0, 7) == 0)
                                                         : ($urandom_range(0, 99) == 0);
            sp = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 3) == 0);
            wa = 4'($urandom_range(0, 15));
            wd[3:2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) wd[1:0] = 2'($urandom_range(1, 2));
            else wd[1:0] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            if ((m_mode == M_IDLE || m_mode == M_DONE) && $urandom_range(0, 3) == 0)
                rl = 5'($urandom_range(0, 20));
            model_step(st, sp, we, wa, wd, s, rl);
            bus.start = st; bus.stop = sp; bus.wr_en = we; bus.wr_addr = wa;
            bus.wr_data = wd; bus.line_sensor = s; bus.route_len = rl;
            tick();
            check($sformatf("rand_c%0d", c), 32'(dut_outs()), 32'(model_outs()));
            check($sformatf("rand_excl_c%0d", c),
                  32'(bus.activate_pick_operation & bus.activate_place_operation), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
